vector_operand_loader: RTL and testbench
========================================

Name: vector_operand_loader

Overview:
- Feeds operands to the fixed-point dot-product datapath. This is the producer/writer side of that unit's vector interface.
- Accepts element pairs (a_i, b_i) serially over a valid/ready stream. Assembles them into N-wide signed vectors.
- Presents a complete vector pair with a valid/ready handshake to the combinational dot-product consumer.
- Supports short vectors terminated early by in_last, zero-padded to N.

Parameters:
- WIDTH, `FP_WIDTH, bit width of each fixed-point element, same format as the dot-product datapath.
- N, 4, vector dimensionality. Must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  element pair on in_a/in_b is valid.
- in_ready  output  1  loader can accept an element this cycle.
- in_a  input  WIDTH (signed)  element of vector a.
- in_b  input  WIDTH (signed)  element of vector b.
- in_last  input  1  this element is the final one of the current vector.
- vec_valid  output  1  vec_a/vec_b hold a complete vector pair.
- vec_ready  input  1  consumer accepts the vector pair this cycle.
- vec_a  output  N x WIDTH (signed, unpacked array)  assembled vector a.
- vec_b  output  N x WIDTH (signed, unpacked array)  assembled vector b.
- vec_len  output  $clog2(N+1)  number of real (non-padded) elements in the presented vector, 1..N.

Behaviour:
- Reset (rst=1 at rising edge, any state, including mid-fill or while presenting):
  - state=FILL, element index idx=0.
  - All vec_a/vec_b entries = 0, vec_len=0, vec_valid=0.
  - Any partial vector is discarded.
  - in_ready=1 from the first cycle after reset deasserts.
- States:
  - FILL: in_ready=1, vec_valid=0.
  - FULL: in_ready=0, vec_valid=1.
- Acceptance in FILL: an element is accepted on a rising edge with in_valid=1 and in_ready=1.
  - vec_a[idx] <= in_a, vec_b[idx] <= in_b.
  - Elements land at indices 0,1,2,... in arrival order.
- Completion: if in_last=1 or idx==N-1 on the accepting edge:
  - Entries idx+1..N-1 are written 0 on that same edge.
  - vec_len <= idx+1, idx <= 0, state <= FULL.
  - Otherwise idx <= idx+1.
- Vector boundary without in_last: idx==N-1 completes the vector regardless of in_last. The next accepted element starts a new vector. This is not an error.
- Zero padding keeps the downstream dot product exact, since padded products are 0.
- Latency: vec_valid rises in the cycle after the completing element is accepted.
- FULL:
  - vec_a, vec_b and vec_len are held stable while vec_valid=1 and vec_ready=0.
  - On a rising edge with vec_ready=1: state <= FILL and vec_valid deasserts the next cycle.
  - Vector contents stay as-is until overwritten. Stale entries are irrelevant because vec_valid=0.
- No overlap: in_ready is low for the whole FULL period, including the handshake cycle. Minimum period is N+1 cycles per full vector and 2 cycles per 1-element vector.
- in_valid=0 in FILL: nothing changes and idx holds. Gaps between elements are allowed at any point.
- vec_ready while in FILL is ignored.
- No arithmetic is done here. Elements are passed bit-exact and the sign is preserved.
- Output timing: in_ready and vec_valid are decoded purely from state, with no combinational path from in_valid or vec_ready.

Test Plan:
- Reset release, then 4 pairs a={1,2,3,4}, b={5,6,7,8} with in_last on the 4th and vec_ready=1 → vec_valid 1 cycle after 4th accept; vec_a={1,2,3,4}, vec_b={5,6,7,8}, vec_len=4; vec_valid drops next cycle; in_ready=1 again.
- Short vector: pairs (3,-2),(−1,4) with in_last on the 2nd → vec_a={3,-1,0,0}, vec_b={-2,4,0,0}, vec_len=2.
- Backpressure: complete a vector with vec_ready=0 for 5 cycles, while driving in_valid=1 with new data → vec outputs stable for all 5 cycles; in_ready=0; no element absorbed; after vec_ready=1 the next element lands at index 0.
- No in_last: stream 8 pairs a=b={1..8} back-to-back, vec_ready always 1 → two vectors, {1,2,3,4} then {5,6,7,8}, each with vec_len=4; exactly 1 stall cycle between them.
- Reset mid-operation:
  - Assert rst after 2 of 4 elements → vec_valid=0, outputs 0; next 4 elements {9,10,11,12} form a clean vector with no residue.
  - Repeat with rst asserted while in FULL → vector dropped.
- Extremes with in_valid toggling randomly: elements -2^(WIDTH-1) and 2^(WIDTH-1)-1 → passed bit-exact; order preserved across gaps.

Source files
------------

// File: rtl/vector_operand_loader.sv
// ============================================================================
// Module   : vector_operand_loader
// Purpose  : Assembles serial (a_i, b_i) element pairs into zero-padded N-wide
//            signed vector pairs for the dot-product datapath.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef FP_WIDTH
`define FP_WIDTH 16
`endif

module vector_operand_loader #(
  parameter int WIDTH = `FP_WIDTH,
  parameter int N     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [WIDTH-1:0]       in_a,
  input  logic signed [WIDTH-1:0]       in_b,
  input  logic                          in_last,
  output logic                          vec_valid,
  input  logic                          vec_ready,
  output logic signed [WIDTH-1:0]       vec_a [N],
  output logic signed [WIDTH-1:0]       vec_b [N],
  output logic [$clog2(N+1)-1:0]        vec_len
);

  localparam int IW = $clog2(N);
  localparam int LW = $clog2(N+1);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic signed [WIDTH-1:0] r_vec_a [N];
  logic signed [WIDTH-1:0] r_vec_b [N];
  logic [LW-1:0]         r_len;

  logic w_accept;
  logic w_done;

  assign w_accept = (r_state == S_FILL) && in_valid;
  // A vector closes on an explicit last or when the final slot is filled.
  assign w_done   = in_last || (r_idx == IW'(N-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
      r_idx   <= '0;
      r_len   <= '0;
      for (int j = 0; j < N; j++) begin
        r_vec_a[j] <= '0;
        r_vec_b[j] <= '0;
      end
    end else if (r_state == S_FILL) begin
      if (w_accept) begin
        // Pad the tail with zeros so padded products contribute nothing.
        for (int j = 0; j < N; j++) begin
          if (j == int'(r_idx)) begin
            r_vec_a[j] <= in_a;
            r_vec_b[j] <= in_b;
          end else if (w_done && (j > int'(r_idx))) begin
            r_vec_a[j] <= '0;
            r_vec_b[j] <= '0;
          end
        end
        if (w_done) begin
          r_len   <= LW'(r_idx) + LW'(1);
          r_idx   <= '0;
          r_state <= S_FULL;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
    end else begin
      if (vec_ready) begin
        r_state <= S_FILL;
      end
    end
  end

  assign in_ready  = (r_state == S_FILL);
  assign vec_valid = (r_state == S_FULL);
  assign vec_a     = r_vec_a;
  assign vec_b     = r_vec_b;
  assign vec_len   = r_len;

endmodule

`default_nettype wire

// File: tb/tb_vector_operand_loader.sv
// ============================================================================
// Module   : tb_vector_operand_loader
// Purpose  : Directed scoreboard bench for vector_operand_loader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vector_operand_loader;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int MX = 32767;
  localparam int MN = -32768;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   in_a;
  logic signed [W-1:0]   in_b;
  logic                  in_last;
  logic                  vec_valid;
  logic                  vec_ready;
  logic signed [W-1:0]   vec_a [N];
  logic signed [W-1:0]   vec_b [N];
  logic [2:0]            vec_len;

  typedef struct {
    logic signed [W-1:0] a [N];
    logic signed [W-1:0] b [N];
    int                  len;
  } exp_t;

  exp_t q [$];
  int   n_assert = 0;
  int   n_fail   = 0;

  vector_operand_loader #(.WIDTH(W), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .vec_a    (vec_a),
    .vec_b    (vec_b),
    .vec_len  (vec_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push4(input int a0, a1, a2, a3, input int b0, b1, b2, b3, input int len);
    exp_t e;
    e.a[0] = W'(a0); e.a[1] = W'(a1); e.a[2] = W'(a2); e.a[3] = W'(a3);
    e.b[0] = W'(b0); e.b[1] = W'(b1); e.b[2] = W'(b2); e.b[3] = W'(b3);
    e.len  = len;
    q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int a, input int b, input logic last, output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_a     = W'(a);
    in_b     = W'(b);
    in_last  = last;
    while (!in_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_vec_valid"}, 64'(vec_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_vec_len"},   64'(vec_len),   64'd0);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_vec_a"}, vec_a[i], 64'd0);
      chk({tag, "_vec_b"}, vec_b[i], 64'd0);
    end
  endtask

  // Scoreboard: compare on every accepted vector handshake.
  always @(posedge clk) begin
    if (!rst && vec_valid && vec_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_vector", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        for (int i = 0; i < N; i++) begin
          chk("sb_vec_a", vec_a[i], e.a[i]);
          chk("sb_vec_b", vec_b[i], e.b[i]);
        end
        chk("sb_vec_len", 64'(vec_len), 64'(e.len));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int st;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; vec_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vec_valid", 64'(vec_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_cleared("reset");

    // Full vector with in_last on the 4th element
    vec_ready = 1'b1;
    push4(1, 2, 3, 4, 5, 6, 7, 8, 4);
    send(1, 5, 1'b0, st);
    send(2, 6, 1'b0, st);
    send(3, 7, 1'b0, st);
    send(4, 8, 1'b1, st);
    chk("t1_latency_vec_valid", 64'(vec_valid), 64'd1);
    chk("t1_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("t1_vec_valid_drop", 64'(vec_valid), 64'd0);
    chk("t1_in_ready_back", 64'(in_ready), 64'd1);

    // Short vector, zero padded
    push4(3, -1, 0, 0, -2, 4, 0, 0, 2);
    send(3, -2, 1'b0, st);
    send(-1, 4, 1'b1, st);
    chk("t2_vec_valid", 64'(vec_valid), 64'd1);
    @(negedge clk);

    // Backpressure with new data pending
    vec_ready = 1'b0;
    push4(11, 12, 13, 14, -11, -12, -13, -14, 4);
    send(11, -11, 1'b0, st);
    send(12, -12, 1'b0, st);
    send(13, -13, 1'b0, st);
    send(14, -14, 1'b1, st);
    in_valid = 1'b1; in_a = 16'sd99; in_b = 16'sd98; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_vec_valid", 64'(vec_valid), 64'd1);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      chk("bp_vec_len",   64'(vec_len),   64'd4);
      for (int i = 0; i < N; i++) begin
        chk("bp_vec_a", vec_a[i], 64'(11 + i));
        chk("bp_vec_b", vec_b[i], 64'(-(11 + i)));
      end
      @(negedge clk);
    end
    vec_ready = 1'b1;
    push4(99, 0, 0, 0, 98, 0, 0, 0, 1);
    send(99, 98, 1'b1, st);
    chk("bp_single_vec_valid", 64'(vec_valid), 64'd1);
    @(negedge clk);

    // Back-to-back stream without in_last: two vectors, one stall between
    push4(1, 2, 3, 4, 1, 2, 3, 4, 4);
    push4(5, 6, 7, 8, 5, 6, 7, 8, 4);
    for (int i = 1; i <= 8; i++) begin
      send(i, i, 1'b0, st);
      chk("stream_stalls", 64'(st), (i == 5) ? 64'd1 : 64'd0);
    end
    chk("stream_vec_valid", 64'(vec_valid), 64'd1);
    @(negedge clk);

    // Reset mid-fill: partial vector discarded
    send(20, 21, 1'b0, st);
    send(22, 23, 1'b0, st);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cleared("rst_fill");
    push4(9, 10, 11, 12, 13, 14, 15, 16, 4);
    send(9, 13, 1'b0, st);
    send(10, 14, 1'b0, st);
    send(11, 15, 1'b0, st);
    send(12, 16, 1'b0, st);
    chk("rst_fill_clean_valid", 64'(vec_valid), 64'd1);
    @(negedge clk);

    // Reset while presenting: vector dropped
    vec_ready = 1'b0;
    send(30, 31, 1'b0, st);
    send(32, 33, 1'b0, st);
    send(34, 35, 1'b0, st);
    send(36, 37, 1'b1, st);
    chk("rst_full_pre_valid", 64'(vec_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cleared("rst_full");
    vec_ready = 1'b1;
    push4(40, 0, 0, 0, 41, 0, 0, 0, 1);
    send(40, 41, 1'b1, st);
    @(negedge clk);

    // Extremes with random input gaps
    push4(MN, MX, MX, MN, MX, MN, MN, MX, 4);
    push4(MX, MN, 1, 0, MN, -1, MX, 0, 3);
    begin
      int ea [7] = '{MN, MX, MX, MN, MX, MN, 1};
      int eb [7] = '{MX, MN, MN, MX, MN, -1, MX};
      for (int i = 0; i < 7; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(ea[i], eb[i], (i == 6), st);
      end
    end
    repeat (3) @(negedge clk);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
